// File: rtl/bp_me_cce_mem_arbiter.sv
// Round-robin arbiter sharing one CCE-to-memory command channel among num_req_p requesters.
// Grant order is recorded in an order FIFO so in-order memory responses return to their owner.
module bp_me_cce_mem_arbiter #(
  parameter int unsigned num_req_p         = 4,
  parameter int unsigned cmd_width_p       = 128,
  parameter int unsigned resp_width_p      = 128,
  parameter int unsigned max_outstanding_p = 8
) (
  input  logic                             clk_i,
  input  logic                             reset_i,

  input  logic [num_req_p*cmd_width_p-1:0] req_cmd_i,
  input  logic [num_req_p-1:0]             req_cmd_v_i,
  output logic [num_req_p-1:0]             req_cmd_ready_o,

  output logic [cmd_width_p-1:0]           mem_cmd_o,
  output logic                             mem_cmd_v_o,
  input  logic                             mem_cmd_ready_i,

  input  logic [resp_width_p-1:0]          mem_resp_i,
  input  logic                             mem_resp_v_i,
  output logic                             mem_resp_yumi_o,

  output logic [resp_width_p-1:0]          req_resp_o,
  output logic [num_req_p-1:0]             req_resp_v_o,
  input  logic [num_req_p-1:0]             req_resp_yumi_i,

  output logic [((num_req_p > 1) ? $clog2(num_req_p) : 1)-1:0] grant_id_o
);

  localparam int unsigned IdW  = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int unsigned PtrW = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
  localparam int unsigned CntW = PtrW + 1;

  if (num_req_p < 2) begin : g_bad_num_req
    $fatal(1, "bp_me_cce_mem_arbiter: num_req_p must be >= 2");
  end
  if ((max_outstanding_p < 1) || ((max_outstanding_p & (max_outstanding_p - 1)) != 0))
  begin : g_bad_depth
    $fatal(1, "bp_me_cce_mem_arbiter: max_outstanding_p must be a power of 2");
  end

  logic [IdW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            full_q, empty_q;
  logic [IdW-1:0]  fifo_q [max_outstanding_p];

  logic [IdW-1:0]  winner;
  logic            any_v;
  int unsigned     idx;
  logic            cmd_ok;
  logic            push, pop;
  logic [IdW-1:0]  head;
  logic            resp_ok;

  // First valid requester at or after rr_ptr, wrapping modulo num_req_p.
  always_comb begin
    winner = rr_ptr_q;
    any_v  = 1'b0;
    idx    = 0;
    for (int unsigned k = 0; k < num_req_p; k++) begin
      idx = 32'(rr_ptr_q) + k;
      if (idx >= num_req_p) begin
        idx = idx - num_req_p;
      end
      if (!any_v && req_cmd_v_i[idx]) begin
        any_v  = 1'b1;
        winner = IdW'(idx);
      end
    end
  end

  assign cmd_ok      = !reset_i && any_v && !full_q;
  assign mem_cmd_v_o = cmd_ok;
  assign mem_cmd_o   = req_cmd_i[32'(winner)*cmd_width_p +: cmd_width_p];
  assign grant_id_o  = winner;
  assign push        = cmd_ok && mem_cmd_ready_i;

  assign head            = fifo_q[rd_ptr_q];
  assign resp_ok         = !reset_i && mem_resp_v_i && !empty_q;
  assign req_resp_o      = mem_resp_i;
  assign mem_resp_yumi_o = resp_ok && req_resp_yumi_i[head];
  assign pop             = mem_resp_yumi_o;

  always_comb begin
    req_cmd_ready_o = '0;
    req_resp_v_o    = '0;
    for (int unsigned i = 0; i < num_req_p; i++) begin
      req_cmd_ready_o[i] = push && (winner == IdW'(i)) && req_cmd_v_i[i];
      req_resp_v_o[i]    = resp_ok && (head == IdW'(i));
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (push) begin
      rr_ptr_d = (winner == IdW'(num_req_p - 1)) ? '0 : winner + 1'b1;
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_ptr_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == CntW'(max_outstanding_p));
      empty_q  <= (count_d == '0);
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= winner;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(mem_resp_v_i && empty_q))
        else $warning("resp with no outstanding cmd");
    end
  end
`endif

endmodule

// File: tb/tb_bp_me_cce_mem_arbiter.sv
// Directed bench for bp_me_cce_mem_arbiter: a queue-based model checked every cycle,
// plus literal expectations for grant order, full blocking and response routing.
module tb_bp_me_cce_mem_arbiter;

  localparam int N = 4;
  localparam int W = 128;
  localparam int D = 8;

  logic           clk_i = 1'b0;
  logic           reset_i;
  logic [N*W-1:0] req_cmd;
  logic [N-1:0]   req_v;
  logic [N-1:0]   req_rdy;
  logic [W-1:0]   mem_cmd;
  logic           mem_cmd_v;
  logic           mem_ready;
  logic [W-1:0]   mem_resp;
  logic           mem_resp_v;
  logic           mem_yumi;
  logic [W-1:0]   req_resp;
  logic [N-1:0]   req_resp_v;
  logic [N-1:0]   req_yumi;
  logic [1:0]     grant;

  int nvec = 0;
  int nerr = 0;

  always #5 clk_i = ~clk_i;

  bp_me_cce_mem_arbiter #(
    .num_req_p(N), .cmd_width_p(W), .resp_width_p(W), .max_outstanding_p(D)
  ) dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .req_cmd_i       (req_cmd),
    .req_cmd_v_i     (req_v),
    .req_cmd_ready_o (req_rdy),
    .mem_cmd_o       (mem_cmd),
    .mem_cmd_v_o     (mem_cmd_v),
    .mem_cmd_ready_i (mem_ready),
    .mem_resp_i      (mem_resp),
    .mem_resp_v_i    (mem_resp_v),
    .mem_resp_yumi_o (mem_yumi),
    .req_resp_o      (req_resp),
    .req_resp_v_o    (req_resp_v),
    .req_resp_yumi_i (req_yumi),
    .grant_id_o      (grant)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: outstanding owners as a queue, round-robin pointer as an integer.
  int q[$];
  int rr = 0;

  always @(negedge clk_i) begin : cmp
    int win, j;
    bit any, full, empty;
    logic [N-1:0] e_rdy, e_rv;
    logic e_mv, e_yumi;
    if (reset_i) begin
      chk("m_rst_cmd_v", W'(mem_cmd_v), '0);
      chk("m_rst_rdy", W'(req_rdy), '0);
      chk("m_rst_resp_v", W'(req_resp_v), '0);
      chk("m_rst_yumi", W'(mem_yumi), '0);
      q.delete();
      rr = 0;
    end else begin
      any = 0;
      win = rr;
      for (int k = 0; k < N; k++) begin
        j = (rr + k) % N;
        if (!any && req_v[j]) begin
          any = 1;
          win = j;
        end
      end
      full   = (q.size() == D);
      empty  = (q.size() == 0);
      e_mv   = any && !full;
      e_rdy  = (e_mv && mem_ready) ? N'(1 << win) : '0;
      e_rv   = (mem_resp_v && !empty) ? N'(1 << q[0]) : '0;
      e_yumi = (e_rv != '0) && req_yumi[q[0]];
      chk("m_cmd_v", W'(mem_cmd_v), W'(e_mv));
      chk("m_rdy", W'(req_rdy), W'(e_rdy));
      chk("m_resp_v", W'(req_resp_v), W'(e_rv));
      chk("m_yumi", W'(mem_yumi), W'(e_yumi));
      if (any) begin
        chk("m_grant", W'(grant), W'(win));
        chk("m_cmd", mem_cmd, req_cmd[win*W +: W]);
      end
      if (mem_resp_v) chk("m_resp", req_resp, mem_resp);
      if (e_yumi) void'(q.pop_front());
      if (e_mv && mem_ready) begin
        q.push_back(win);
        rr = (win + 1) % N;
      end
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drain(input int n);
    mem_resp_v = 1'b1;
    req_yumi   = '1;
    repeat (n) cyc();
    mem_resp_v = 1'b0;
    req_yumi   = '0;
  endtask

  int g2[5];
  int g3[3];
  int exp2[5] = '{0, 1, 2, 3, 0};
  int exp3[3] = '{3, 1, 3};
  int acc;

  initial begin
    reset_i    = 1'b1;
    req_v      = '1;
    mem_ready  = 1'b1;
    mem_resp   = '0;
    mem_resp_v = 1'b0;
    req_yumi   = '0;
    for (int i = 0; i < N; i++) begin
      req_cmd[i*W +: W] = {64'hFACE_0000_0000_0000 + 64'(i), 64'(i * 3 + 7)};
    end

    // Reset held with every requester valid.
    repeat (3) begin
      @(negedge clk_i);
      chk("rst_cmd_v", W'(mem_cmd_v), '0);
      chk("rst_rdy", W'(req_rdy), '0);
    end
    cyc();
    reset_i = 1'b0;

    // Fairness with everyone valid.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      g2[k] = int'(grant);
      cyc();
    end
    chk("post_rst_grant", W'(g2[0]), '0);
    for (int k = 0; k < 5; k++) chk("fair_grant", W'(g2[k]), W'(exp2[k]));
    req_v = '0;
    drain(5);

    // Move rr_ptr to 2, then only 1 and 3 valid.
    req_v = 4'b0010;
    cyc();
    req_v = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      g3[k] = int'(grant);
      cyc();
    end
    for (int k = 0; k < 3; k++) chk("skip_grant", W'(g3[k]), W'(exp3[k]));
    req_v = '0;
    drain(4);

    // Full: 9 offered, 8 accepted; a pop does not reopen the same cycle.
    req_v = 4'b0001;
    acc   = 0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk_i);
      acc += int'(req_rdy[0]);
      if (k == 8) chk("full_blocked", W'(mem_cmd_v), '0);
      cyc();
    end
    chk("full_accepted", W'(acc), W'(8));
    mem_resp_v = 1'b1;
    req_yumi   = '1;
    @(negedge clk_i);
    chk("full_pop_yumi", W'(mem_yumi), W'(1));
    chk("full_same_cycle", W'(mem_cmd_v), '0);
    cyc();
    mem_resp_v = 1'b0;
    req_yumi   = '0;
    @(negedge clk_i);
    chk("full_reopen", W'(mem_cmd_v), W'(1));
    cyc();
    req_v = '0;
    drain(8);

    // Ordering: commands from 2, 0, 2.
    req_v = 4'b0100; cyc();
    req_v = 4'b0001; cyc();
    req_v = 4'b0100; cyc();
    req_v = '0;
    mem_resp   = 128'hAAAA;
    mem_resp_v = 1'b1;
    req_yumi   = '0;
    @(negedge clk_i);
    chk("ord_a_v", W'(req_resp_v), W'(4'b0100));
    chk("ord_a_stall", W'(mem_yumi), '0);
    chk("ord_a_data", req_resp, 128'hAAAA);
    cyc();
    req_yumi = 4'b0100;
    @(negedge clk_i);
    chk("ord_a_yumi", W'(mem_yumi), W'(1));
    cyc();
    mem_resp = 128'hBBBB;
    @(negedge clk_i);
    chk("ord_b_v", W'(req_resp_v), W'(4'b0001));
    chk("ord_b_nonhead", W'(mem_yumi), '0);
    cyc();
    req_yumi = 4'b0001;
    @(negedge clk_i);
    chk("ord_b_yumi", W'(mem_yumi), W'(1));
    cyc();
    mem_resp = 128'hCCCC;
    req_yumi = 4'b0100;
    @(negedge clk_i);
    chk("ord_c_v", W'(req_resp_v), W'(4'b0100));
    chk("ord_c_yumi", W'(mem_yumi), W'(1));
    cyc();
    mem_resp_v = 1'b0;
    req_yumi   = '0;

    // Simultaneous push/pop at count 3, then exactly 5 more fit.
    req_v = 4'b0001;
    repeat (3) cyc();
    mem_resp_v = 1'b1;
    req_yumi   = '1;
    @(negedge clk_i);
    chk("pp_push", W'(req_rdy), W'(4'b0001));
    chk("pp_pop", W'(mem_yumi), W'(1));
    cyc();
    mem_resp_v = 1'b0;
    req_yumi   = '0;
    req_v      = 4'b0010;
    acc        = 0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk_i);
      acc += int'(req_rdy[1]);
      cyc();
    end
    chk("pp_count_held", W'(acc), W'(5));
    req_v = '0;
    drain(8);

    // Stray response with nothing outstanding.
    mem_resp_v = 1'b1;
    req_yumi   = '1;
    @(negedge clk_i);
    chk("stray_yumi", W'(mem_yumi), '0);
    chk("stray_resp_v", W'(req_resp_v), '0);
    cyc();
    mem_resp_v = 1'b0;
    req_yumi   = '0;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
